// File: rtl/intr_controller.sv
// intr_controller
//   Four-source fixed-priority interrupt controller with a single vector
//   request to the CPU. Source 0 (done1) has the highest priority.
//
//   Build option:
//     INTR_EDGE_EN  defined   -> rising-edge events; each source keeps a
//                                history flop, so a held-high done gives one event
//                   undefined -> level events; every cycle done=1 sets pending
//
//   Ports:
//     clk          clock, rising edge
//     reset        asynchronous, active-low reset
//     done1..done4 completion events, sources 0..3
//     mask[3:0]    per-source enable (1 = enabled)
//     status_bit   CPU interrupt-disable / in-service flag, blocks new requests
//     int_ack      CPU accept pulse
//     eoi          end-of-interrupt pulse
//     interrupt    registered request to the CPU
//     int_addr     registered vector address
//     int_id       registered id of the requested / serviced source
//     pending      registered pending flags
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no request outstanding, scanning pending&mask
//   REQ     | interrupt asserted, id/addr frozen until ack
//   SERVICE | CPU accepted, waiting for eoi
module intr_controller #(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int unsigned VEC_SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done1,
    input  logic        done2,
    input  logic        done3,
    input  logic        done4,
    input  logic [3:0]  mask,
    input  logic        status_bit,
    input  logic        int_ack,
    input  logic        eoi,
    output logic        interrupt,
    output logic [31:0] int_addr,
    output logic [1:0]  int_id,
    output logic [3:0]  pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  done_vec;
    logic [3:0]  evt;
    logic [3:0]  qual;
    logic [3:0]  clr_vec;
    logic [3:0]  pending_nxt;
    logic [1:0]  id_sel;
    logic [1:0]  int_id_nxt;
    logic [31:0] int_addr_nxt;
    logic        interrupt_nxt;
    logic        ack_clr;

    assign done_vec = {done4, done3, done2, done1};

`ifdef INTR_EDGE_EN
    logic [3:0] done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 4'b0000;
        end else begin
            done_q <= done_vec;
        end
    end

    assign evt = done_vec & ~done_q;
`else
    assign evt = done_vec;
`endif

    assign qual = pending & mask;

    // Lowest-numbered qualifying source wins; scan from the top so the
    // last assignment is the highest priority one.
    always_comb begin
        id_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (qual[i]) begin
                id_sel = i[1:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        interrupt_nxt = interrupt;
        int_id_nxt    = int_id;
        int_addr_nxt  = int_addr;
        ack_clr       = 1'b0;
        case (state)
            IDLE: begin
                if ((qual != 4'b0000) && !status_bit) begin
                    state_nxt     = REQ;
                    interrupt_nxt = 1'b1;
                    int_id_nxt    = id_sel;
                    int_addr_nxt  = VEC_BASE + ({30'd0, id_sel} << VEC_SHIFT);
                end
            end
            REQ: begin
                // A withdrawn mask cancels the request even if ack arrives
                // in the same cycle; the pending bit is kept for later.
                if (!mask[int_id]) begin
                    state_nxt     = IDLE;
                    interrupt_nxt = 1'b0;
                end else if (int_ack) begin
                    state_nxt     = SERVICE;
                    interrupt_nxt = 1'b0;
                    ack_clr       = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                interrupt_nxt = 1'b0;
            end
        endcase
    end

    // New events are OR-ed in after the ack clear so a coincident set wins.
    assign clr_vec     = ack_clr ? (4'b0001 << int_id) : 4'b0000;
    assign pending_nxt = (pending & ~clr_vec) | evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            int_id    <= 2'd0;
            int_addr  <= 32'd0;
            pending   <= 4'b0000;
        end else begin
            state     <= state_nxt;
            interrupt <= interrupt_nxt;
            int_id    <= int_id_nxt;
            int_addr  <= int_addr_nxt;
            pending   <= pending_nxt;
        end
    end

endmodule
